// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right/left, parallel load, with a
// frame counter that pulses FRAME every FRAME_LEN shifts.
//
// Ports:
//   C      clock, all state changes on the rising edge
//   CLR    synchronous active-high reset
//   EN     clock enable (0 freezes state, FRAME forced low)
//   MODE   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   SIR    serial in for right shift (enters Q[WIDTH-1])
//   SIL    serial in for left shift (enters Q[0])
//   PI     parallel load data
//   Q      register contents
//   SOR    right-shift serial out, Q[0]
//   SOL    left-shift serial out, Q[WIDTH-1]
//   CNT    shifts completed in the current frame
//   BUSY   a frame is partially shifted
//   FRAME  one-cycle pulse after the frame-completing shift
module shift_reg_univ #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 8,
    localparam int CW       = $clog2(FRAME_LEN + 1)
) (
    input  logic             C,
    input  logic             CLR,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             SIR,
    input  logic             SIL,
    input  logic [WIDTH-1:0] PI,
    output logic [WIDTH-1:0] Q,
    output logic             SOR,
    output logic             SOL,
    output logic [CW-1:0]    CNT,
    output logic             BUSY,
    output logic             FRAME
);

    typedef enum logic {
        IDLE,
        SHIFTING
    } state_t;

    localparam logic          DIR_R = 1'b0;
    localparam logic          DIR_L = 1'b1;
    localparam logic [CW-1:0] FL    = CW'(FRAME_LEN);

    state_t           state, state_n;
    logic             dir, dir_n;
    logic [WIDTH-1:0] q_n;
    logic [CW-1:0]    cnt_n;
    logic             frame_n;

    logic             is_shift;
    logic             shift_dir;
    logic [CW-1:0]    n;
    logic [CW-1:0]    n1;

    always_ff @(posedge C) begin
        if (CLR) begin
            Q     <= '0;
            CNT   <= '0;
            FRAME <= 1'b0;
            state <= IDLE;
            dir   <= DIR_R;
        end else begin
            Q     <= q_n;
            CNT   <= cnt_n;
            FRAME <= frame_n;
            state <= state_n;
            dir   <= dir_n;
        end
    end

    always_comb begin
        q_n       = Q;
        cnt_n     = CNT;
        frame_n   = 1'b0;
        state_n   = state;
        dir_n     = dir;
        is_shift  = (MODE == 2'b01) || (MODE == 2'b10);
        shift_dir = (MODE == 2'b10) ? DIR_L : DIR_R;
        // Reversing direction mid-frame restarts the count, so this
        // shift becomes shift 1 of a fresh frame.
        if ((state == SHIFTING) && (shift_dir != dir)) begin
            n = '0;
        end else begin
            n = CNT;
        end
        n1 = n + CW'(1);

        if (EN) begin
            unique case (MODE)
                2'b00: begin
                end
                2'b01: begin
                    q_n   = {SIR, Q[WIDTH-1:1]};
                    dir_n = DIR_R;
                end
                2'b10: begin
                    q_n   = {Q[WIDTH-2:0], SIL};
                    dir_n = DIR_L;
                end
                2'b11: begin
                    q_n     = PI;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase

            if (is_shift) begin
                if (n1 == FL) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    frame_n = 1'b1;
                end else begin
                    cnt_n   = n1;
                    state_n = SHIFTING;
                end
            end
        end
    end

    assign SOR  = Q[0];
    assign SOL  = Q[WIDTH-1];
    assign BUSY = (state == SHIFTING);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: FRAME_LEN=8 and FRAME_LEN=1 instances
// share the same stimulus; each task checks its own scenario.
module tb_shift_reg_univ;

    logic       c;
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       sir;
    logic       sil;
    logic [7:0] pi;

    logic [7:0] q8;
    logic       sor8, sol8, busy8, frame8;
    logic [3:0] cnt8;

    logic [7:0] q1;
    logic       sor1, sol1, busy1, frame1;
    logic [0:0] cnt1;

    int vectors    = 0;
    int miscompares = 0;

    shift_reg_univ #(.WIDTH(8), .FRAME_LEN(8)) u8 (
        .C(c), .CLR(clr), .EN(en), .MODE(mode),
        .SIR(sir), .SIL(sil), .PI(pi),
        .Q(q8), .SOR(sor8), .SOL(sol8),
        .CNT(cnt8), .BUSY(busy8), .FRAME(frame8)
    );

    shift_reg_univ #(.WIDTH(8), .FRAME_LEN(1)) u1 (
        .C(c), .CLR(clr), .EN(en), .MODE(mode),
        .SIR(sir), .SIL(sil), .PI(pi),
        .Q(q1), .SOR(sor1), .SOL(sol1),
        .CNT(cnt1), .BUSY(busy1), .FRAME(frame1)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic test_reset();
        clr  = 1'b1;
        en   = 1'b1;
        mode = 2'b11;
        pi   = 8'hFF;
        sir  = 1'b0;
        sil  = 1'b0;
        tick();
        tick();
        vectors++;
        if (q8 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_q got %h want 00", q8);
        end
        vectors++;
        if (cnt8 !== 4'd0 || busy8 !== 1'b0 || frame8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got cnt=%0d busy=%b frame=%b want 0/0/0",
                     cnt8, busy8, frame8);
        end
        vectors++;
        if (sor8 !== 1'b0 || sol8 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_so got sor=%b sol=%b want 0/0", sor8, sol8);
        end
        clr = 1'b0;
    endtask

    task automatic test_deserialise();
        logic [7:0] bits;
        logic [3:0] exp_cnt;
        bits = 8'b1011_0100;
        mode = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            sir = bits[i-1];
            tick();
            exp_cnt = (i == 8) ? 4'd0 : 4'(i);
            vectors++;
            if (cnt8 !== exp_cnt || busy8 !== (i < 8) || frame8 !== (i == 8)) begin
                miscompares++;
                $display("FAIL deser_e%0d got cnt=%0d busy=%b frame=%b want %0d/%b/%b",
                         i, cnt8, busy8, frame8, exp_cnt, (i < 8), (i == 8));
            end
        end
        vectors++;
        if (q8 !== 8'hB4) begin
            miscompares++;
            $display("FAIL deser_q got %h want b4", q8);
        end
        mode = 2'b00;
        tick();
        vectors++;
        if (frame8 !== 1'b0 || q8 !== 8'hB4) begin
            miscompares++;
            $display("FAIL deser_after got frame=%b q=%h want 0/b4", frame8, q8);
        end
    endtask

    task automatic test_serialise_left();
        logic [7:0] exp_sol;
        int         frames;
        exp_sol = 8'b1010_0101;
        mode = 2'b11;
        pi   = 8'hA5;
        tick();
        vectors++;
        if (q8 !== 8'hA5 || cnt8 !== 4'd0) begin
            miscompares++;
            $display("FAIL ser_load got q=%h cnt=%0d want a5/0", q8, cnt8);
        end
        mode   = 2'b10;
        sil    = 1'b0;
        frames = 0;
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (sol8 !== exp_sol[7-i]) begin
                miscompares++;
                $display("FAIL ser_sol_b%0d got %b want %b", i, sol8, exp_sol[7-i]);
            end
            tick();
            if (frame8 === 1'b1) frames++;
        end
        vectors++;
        if (q8 !== 8'h00 || frames != 1 || frame8 !== 1'b1) begin
            miscompares++;
            $display("FAIL ser_end got q=%h frames=%0d frame=%b want 00/1/1",
                     q8, frames, frame8);
        end
    endtask

    task automatic test_enable_hold_dir();
        logic [3:0] exp_cnt;
        mode = 2'b11;
        pi   = 8'h81;
        tick();
        mode = 2'b01;
        sir  = 1'b1;
        repeat (3) tick();
        vectors++;
        if (q8 !== 8'hF0 || cnt8 !== 4'd3 || busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL ehd_shift3 got q=%h cnt=%0d busy=%b want f0/3/1",
                     q8, cnt8, busy8);
        end
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (q8 !== 8'hF0 || cnt8 !== 4'd3 || frame8 !== 1'b0) begin
                miscompares++;
                $display("FAIL ehd_en0_%0d got q=%h cnt=%0d frame=%b want f0/3/0",
                         i, q8, cnt8, frame8);
            end
        end
        en   = 1'b1;
        mode = 2'b00;
        repeat (2) tick();
        vectors++;
        if (q8 !== 8'hF0 || cnt8 !== 4'd3 || busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL ehd_hold got q=%h cnt=%0d busy=%b want f0/3/1",
                     q8, cnt8, busy8);
        end
        mode = 2'b10;
        sil  = 1'b1;
        tick();
        vectors++;
        if (q8 !== 8'hE1 || cnt8 !== 4'd1 || busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL ehd_dirchg got q=%h cnt=%0d busy=%b want e1/1/1",
                     q8, cnt8, busy8);
        end
        sil = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_cnt = (k == 7) ? 4'd0 : 4'(k + 1);
            vectors++;
            if (cnt8 !== exp_cnt || frame8 !== (k == 7)) begin
                miscompares++;
                $display("FAIL ehd_left%0d got cnt=%0d frame=%b want %0d/%b",
                         k, cnt8, frame8, exp_cnt, (k == 7));
            end
        end
        vectors++;
        if (q8 !== 8'h80) begin
            miscompares++;
            $display("FAIL ehd_q got %h want 80", q8);
        end
        en = 1'b0;
        tick();
        vectors++;
        if (frame8 !== 1'b0 || cnt8 !== 4'd0) begin
            miscompares++;
            $display("FAIL ehd_pulse_en0 got frame=%b cnt=%0d want 0/0",
                     frame8, cnt8);
        end
        en = 1'b1;
    endtask

    task automatic test_abort();
        mode = 2'b01;
        sir  = 1'b0;
        repeat (5) tick();
        vectors++;
        if (cnt8 !== 4'd5 || busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre got cnt=%0d busy=%b want 5/1", cnt8, busy8);
        end
        mode = 2'b11;
        pi   = 8'h3C;
        tick();
        vectors++;
        if (q8 !== 8'h3C || cnt8 !== 4'd0 || busy8 !== 1'b0 || frame8 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_load got q=%h cnt=%0d busy=%b frame=%b want 3c/0/0/0",
                     q8, cnt8, busy8, frame8);
        end
        mode = 2'b01;
        sir  = 1'b1;
        repeat (5) tick();
        vectors++;
        if (cnt8 !== 4'd5) begin
            miscompares++;
            $display("FAIL abort_pre2 got cnt=%0d want 5", cnt8);
        end
        clr = 1'b1;
        tick();
        vectors++;
        if (q8 !== 8'h00 || cnt8 !== 4'd0 || busy8 !== 1'b0 || frame8 !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clr got q=%h cnt=%0d busy=%b frame=%b want 00/0/0/0",
                     q8, cnt8, busy8, frame8);
        end
        clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_cnt;
        logic       exp_frame;
        mode = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            sir = i[0];
            tick();
            exp_cnt   = 4'(i % 8);
            exp_frame = (i == 8) || (i == 16);
            vectors++;
            if (cnt8 !== exp_cnt || frame8 !== exp_frame) begin
                miscompares++;
                $display("FAIL b2b_e%0d got cnt=%0d frame=%b want %0d/%b",
                         i, cnt8, frame8, exp_cnt, exp_frame);
            end
        end
        vectors++;
        if (q8 !== 8'h55) begin
            miscompares++;
            $display("FAIL b2b_q got %h want 55", q8);
        end
    endtask

    task automatic test_frame_len1();
        clr = 1'b1;
        tick();
        clr  = 1'b0;
        mode = 2'b01;
        sir  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            vectors++;
            if (frame1 !== 1'b1 || busy1 !== 1'b0 || cnt1 !== 1'b0) begin
                miscompares++;
                $display("FAIL fl1_e%0d got frame=%b busy=%b cnt=%0d want 1/0/0",
                         i, frame1, busy1, cnt1);
            end
        end
        vectors++;
        if (q1 !== 8'hF8) begin
            miscompares++;
            $display("FAIL fl1_q got %h want f8", q1);
        end
        mode = 2'b00;
        tick();
        vectors++;
        if (frame1 !== 1'b0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL fl1_hold got frame=%b busy=%b want 0/0", frame1, busy1);
        end
    endtask

    initial begin
        clr  = 1'b1;
        en   = 1'b0;
        mode = 2'b00;
        sir  = 1'b0;
        sil  = 1'b0;
        pi   = 8'h00;
        test_reset();
        test_deserialise();
        test_serialise_left();
        test_enable_hold_dir();
        test_abort();
        test_back_to_back();
        test_frame_len1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
